// File: rtl/multicycle_adder_pkg.sv
// Package for the multicycle adder.
// Holds the FSM state encoding and the default operand / slice widths.
// Optional feature macro used elsewhere: MULTICYCLE_ADDER_SUBTRACT_EN.
package multicycle_adder_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_SLICE = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/multicycle_adder_slice_adder.sv
// slice_adder: combinational SLICE-bit ripple-carry adder built from
// full-adder cells. Used by multicycle_adder to add one slice per cycle.
// Ports:
//   a_i, b_i   - slice operands
//   ci_i       - carry into bit 0
//   sum_o      - slice sum
//   co_o       - carry out of the slice MSB
//   msb_ci_o   - carry into the slice MSB (for signed overflow detection)
module slice_adder #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             ci_i,
  output logic [SLICE-1:0] sum_o,
  output logic             co_o,
  output logic             msb_ci_o
);

  logic [SLICE:0] c;

  assign c[0] = ci_i;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign co_o     = c[SLICE];
  assign msb_ci_o = c[SLICE-1];

endmodule

// File: rtl/multicycle_adder.sv
// multicycle_adder: adds two WIDTH-bit operands SLICE bits per clock using a
// single slice_adder, with a fixed latency of WIDTH/SLICE ADD cycles.
// Optional feature: define MULTICYCLE_ADDER_SUBTRACT_EN to add the sub input;
// with sub=1 the block computes a - b as a + ~b + 1 (cin ignored).
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - begin an operation (accepted in IDLE or DONE)
//   a, b, cin           - operands and carry-in, sampled on accept
//   sub                 - subtract select (only with the macro defined)
//   busy                - high in ADD
//   done                - one-cycle result-valid pulse (DONE state)
//   sum, cout, overflow - result, carry out of MSB, signed overflow
//   state_dbg           - current FSM state, for observation
// Handshake: start is a request sampled on rising edges only while the FSM is
// in IDLE or DONE; while busy=1 start is ignored. done=1 for exactly one cycle
// and sum/cout/overflow are then held until the next accepted start.
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef MULTICYCLE_ADDER_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  if ((SLICE < 1) || (WIDTH < SLICE) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
    $error("multicycle_adder: WIDTH must be a positive multiple of SLICE");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [SLICE-1:0]  sl_a, sl_b, sl_sum;
  logic              sl_co, sl_msb_ci;

  // Operand slice currently selected by the index.
  always_comb begin
    sl_a = a_q[int'(idx_q)*SLICE +: SLICE];
    sl_b = b_q[int'(idx_q)*SLICE +: SLICE];
  end

  slice_adder #(.SLICE(SLICE)) u_slice_adder (
    .a_i      (sl_a),
    .b_i      (sl_b),
    .ci_i     (carry_q),
    .sum_o    (sl_sum),
    .co_o     (sl_co),
    .msb_ci_o (sl_msb_ci)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          idx_d   = '0;
          state_d = ST_ADD;
`ifdef MULTICYCLE_ADDER_SUBTRACT_EN
          // Subtraction reuses the adder: invert b and force carry-in to 1.
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
`else
          b_d     = b;
          carry_d = cin;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ADD: begin
        sum_d[int'(idx_q)*SLICE +: SLICE] = sl_sum;
        carry_d = sl_co;
        if (idx_q == LAST_IDX) begin
          // Only the top slice defines the word-level carry and overflow.
          cout_d  = sl_co;
          ovf_d   = sl_msb_ci ^ sl_co;
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q == ST_ADD);
  assign done      = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Self-checking bench for multicycle_adder (WIDTH=32, SLICE=8).
module tb_multicycle_adder;

  localparam int W  = 32;
  localparam int SL = 8;
  localparam int NS = W / SL;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, overflow;
  logic [W-1:0] sum;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  multicycle_adder #(.WIDTH(W), .SLICE(SL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef MULTICYCLE_ADDER_SUBTRACT_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [W+1:0] exp_q[$];   // {overflow, cout, sum}
  int           due_q[$];   // cycle at which done must be seen
  logic [W+1:0] last_res = '0;
  bit           cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [W+1:0] act, input logic [W+1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", nm, act, expv, cyc);
    end
  endtask

  // Reference: plain (W+1)-bit arithmetic; signed overflow from operand/result signs.
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic ci, input logic sb);
    logic [W-1:0] bb;
    logic         c;
    logic [W:0]   t;
    logic         ov;
    bb = bv;
    c  = ci;
`ifdef MULTICYCLE_ADDER_SUBTRACT_EN
    if (sb) begin
      bb = ~bv;
      c  = 1'b1;
    end
`endif
    t  = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, c};
    ov = (av[W-1] == bb[W-1]) && (t[W-1] != av[W-1]);
    return {ov, t[W], t[W-1:0]};
  endfunction

  // Per-cycle compare: done/busy timing, result on done, held result when idle.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      logic exp_done, exp_busy;
      logic [W+1:0] r;
      exp_done = (due_q.size() > 0) && (cyc == due_q[0]);
      exp_busy = (due_q.size() > 0) && (cyc >= due_q[0] - NS) && (cyc < due_q[0]);
      chk("done", {{(W+1){1'b0}}, done}, {{(W+1){1'b0}}, exp_done});
      chk("busy", {{(W+1){1'b0}}, busy}, {{(W+1){1'b0}}, exp_busy});
      if (exp_done) begin
        r = exp_q.pop_front();
        void'(due_q.pop_front());
        chk("result", {overflow, cout, sum}, r);
        last_res = r;
      end else if (!exp_busy) begin
        chk("hold", {overflow, cout, sum}, last_res);
      end
    end
  end

  // ---------------- drivers ----------------
  // Present an operation at a negedge; returns at the negedge after the accept edge.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic sb);
    a = av; b = bv; cin = ci; sub = sb; start = 1'b1;
    @(posedge clk);
    due_q.push_back(cyc + NS + 1);
    exp_q.push_back(model(av, bv, ci, sb));
    @(negedge clk);
  endtask

  // Single operation; returns at the negedge of the DONE cycle.
  task automatic run1(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic ci, input logic sb);
    do_op(av, bv, ci, sb);
    start = 1'b0;
    repeat (NS) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {overflow, cout, sum}, '0);
    chk("reset_busy_done", {{W{1'b0}}, busy, done}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // Wrap-around carry out.
    run1(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    #1;
    chk("v_wrap_done", {{(W+1){1'b0}}, done}, 1);
    chk("v_wrap", {overflow, cout, sum}, {1'b0, 1'b1, 32'h0000_0000});
    @(negedge clk);

    // Signed overflow.
    run1(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    #1;
    chk("v_ovf", {overflow, cout, sum}, {1'b0, 1'b1, 32'h8000_0000} ^ {2'b11, 32'h0});
    @(negedge clk);

    // Carry-in honoured.
    run1(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    #1;
    chk("v_cin", {overflow, cout, sum}, {1'b0, 1'b0, 32'h2345_678A});
    repeat (2) @(negedge clk);

    // Input changes and a start pulse during ADD must be ignored.
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    start = 1'b0;
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (NS - 2) @(negedge clk);
    #1;
    chk("v_ignore", {overflow, cout, sum}, {1'b0, 1'b0, 32'h0000_0100});
    repeat (NS + 3) @(negedge clk);

    // Reset mid-operation: outputs clear immediately, no done afterwards.
    do_op(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b1, 1'b0);
    start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {overflow, cout, sum}, '0);
    chk("abort_busy_done", {{W{1'b0}}, busy, done}, '0);
    exp_q.delete();
    due_q.delete();
    last_res = '0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (NS + 2) @(negedge clk);
    run1(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
    #1;
    chk("after_abort", {overflow, cout, sum}, {1'b0, 1'b0, 32'h0000_0007});
    @(negedge clk);

    // Back-to-back stream with start held high.
    do_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 6; i++) begin
      repeat (NS) @(negedge clk);
      do_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end
    start = 1'b0;
    repeat (NS + 2) @(negedge clk);

    // Randomized singles, with occasional boundary operands.
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] av, bv;
      av = $urandom;
      bv = $urandom;
      if ($urandom_range(0, 4) == 0) av = '1;
      if ($urandom_range(0, 4) == 0) bv = 32'h8000_0000;
      run1(av, bv, 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

`ifdef MULTICYCLE_ADDER_SUBTRACT_EN
    @(negedge clk);
    run1(32'd5, 32'd7, 1'b1, 1'b1);
    #1;
    chk("sub_5_7", {overflow, cout, sum}, {1'b0, 1'b0, 32'hFFFF_FFFE});
    @(negedge clk);
    run1(32'd7, 32'd5, 1'b0, 1'b1);
    #1;
    chk("sub_7_5", {overflow, cout, sum}, {1'b0, 1'b1, 32'h0000_0002});
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      run1($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clk);
    end
`endif

    repeat (NS + 3) @(negedge clk);
    chk("drain", W'(due_q.size()), '0);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning total operand width in bits.
REQ-002 The block SHALL have parameter SLICE, default 8, meaning bits added per clock cycle; WIDTH SHALL be an integer multiple of SLICE, checked at elaboration.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port start  input  1  request to begin an addition.
REQ-006 The block SHALL have ports a and b  input  WIDTH  operands, sampled only when start is accepted.
REQ-007 The block SHALL have port cin  input  1  carry-in, sampled only when start is accepted.
REQ-008 The block SHALL have port busy  output  1  high while an operation is in progress (ADD state).
REQ-009 The block SHALL have port done  output  1  one-cycle pulse marking the result as valid.
REQ-010 The block SHALL have port sum  output  WIDTH  result.
REQ-011 The block SHALL have port cout  output  1  carry out of bit WIDTH-1.
REQ-012 The block SHALL have port overflow  output  1  signed overflow, computed as carry into the MSB XOR cout.

Function
REQ-013 The FSM SHALL have three states: IDLE, ADD and DONE.
REQ-014 In IDLE or DONE, start=1 SHALL be accepted: latch a, b and cin; clear the slice index; go to ADD.
REQ-015 In ADD, each cycle SHALL add slice[index] of a and b plus the carry register, write that slice of sum, update the carry register and increment index.
REQ-016 After slice WIDTH/SLICE-1 the FSM SHALL go to DONE; DONE lasts exactly one cycle with done=1, then returns to IDLE unless start=1.
REQ-017 Latency SHALL be fixed: done=1 in the cycle following WIDTH/SLICE rising edges after the accepting edge.
REQ-018 start SHALL be ignored while busy=1; the latched operands SHALL be unaffected by input changes during ADD.
REQ-019 sum, cout and overflow SHALL hold their values from done until the next accepted start, and are undefined-free (hold partial results) during ADD.
REQ-020 start=1 in DONE SHALL produce back-to-back operation with no idle cycle.
REQ-021 With SLICE==WIDTH, the operation SHALL complete in one ADD cycle.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH, with the wrap-out reported on cout.

Reset
REQ-023 rst_n=0 SHALL, asynchronously, force IDLE and clear busy, done, sum, cout, overflow, the carry register and the index, including when asserted mid-operation.
REQ-024 After rst_n deasserts, the first start SHALL be accepted normally; no result from an aborted operation SHALL ever produce done.

Configuration
REQ-025 With macro MULTICYCLE_ADDER_SUBTRACT_EN defined, the block SHALL have an input port sub (1 bit), sampled with start.
REQ-026 With the macro defined and sub=1, the block SHALL compute a - b as a + ~b + 1, ignoring cin; cout=1 then means no borrow.
REQ-027 With the macro undefined, the sub port and the inversion logic SHALL be absent, and the block SHALL only add.

Structure
REQ-028 Package multicycle_adder_pkg SHALL hold the FSM state enum and the default WIDTH and SLICE constants.
REQ-029 Sub-module slice_adder SHALL be a combinational SLICE-bit ripple adder of full-adder cells, with outputs for the slice sum, carry-out and MSB carry-in; it is instantiated once.

Verification
REQ-030 WIDTH=32, SLICE=8: start with a=0xFFFFFFFF, b=1, cin=0 -> done 4 edges later; sum=0, cout=1, overflow=0.
REQ-031 a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, cout=0, overflow=1; a=0x12345678, b=0x11111111, cin=1 -> sum=0x2345678A.
REQ-032 Change a, b and pulse start at cycle 2 of ADD -> the original result is unchanged; the pulse is ignored and only one done occurs.
REQ-033 Assert rst_n=0 during ADD -> all outputs 0 immediately and no done; a new start then completes correctly.
REQ-034 Hold start=1 continuously with new operands each DONE cycle -> results arrive every 5 cycles, each correct.
REQ-035 With the SUBTRACT_EN macro and sub=1: a=5, b=7 -> sum=0xFFFFFFFE, cout=0; a=7, b=5 -> sum=2, cout=1.
